// File: rtl/adma_atx_wrr_arb.sv
// adma_atx_wrr_arb
// Weighted round-robin arbiter for per-channel AXI transaction requests.
// The granted request goes into a registered forward slice.
// Optional feature macro: ADMA_ATX_ARB_OSTD_LIMIT_EN.
//   Defined   - a per-channel outstanding counter blocks a channel that
//               already has CHN_OSTD_MAX transactions in flight.
//   Undefined - no counters are built, and atx_done is ignored.
module adma_atx_wrr_arb #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int DMA_CHN_ARB_W = 3,
    parameter int SRC_ADDR_W    = 32,
    parameter int DST_ADDR_W    = 32,
    parameter int MST_ID_W      = 5,
    parameter int ATX_LEN_W     = 8,
    parameter int CHN_OSTD_MAX  = 2,
    parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DMA_CHN_NUM*MST_ID_W-1:0]      bwd_arid,
    input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0]    bwd_araddr,
    input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]     bwd_arlen,
    input  logic [DMA_CHN_NUM*2-1:0]             bwd_arburst,
    input  logic [DMA_CHN_NUM*MST_ID_W-1:0]      bwd_awid,
    input  logic [DMA_CHN_NUM*DST_ADDR_W-1:0]    bwd_awaddr,
    input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]     bwd_awlen,
    input  logic [DMA_CHN_NUM*2-1:0]             bwd_awburst,
    input  logic [DMA_CHN_NUM-1:0]               bwd_atx_vld,
    output logic [DMA_CHN_NUM-1:0]               bwd_atx_rdy,
    input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0] chn_arb_rate,
    input  logic [DMA_CHN_NUM-1:0]               atx_done,
    output logic [DMA_CHN_NUM_W-1:0]             fwd_atx_chn_id,
    output logic [MST_ID_W-1:0]                  fwd_arid,
    output logic [SRC_ADDR_W-1:0]                fwd_araddr,
    output logic [ATX_LEN_W-1:0]                 fwd_arlen,
    output logic [1:0]                           fwd_arburst,
    output logic [MST_ID_W-1:0]                  fwd_awid,
    output logic [DST_ADDR_W-1:0]                fwd_awaddr,
    output logic [ATX_LEN_W-1:0]                 fwd_awlen,
    output logic [1:0]                           fwd_awburst,
    output logic                                 fwd_atx_vld,
    input  logic                                 fwd_atx_rdy
);

    logic [MST_ID_W-1:0]      arid_a    [DMA_CHN_NUM];
    logic [SRC_ADDR_W-1:0]    araddr_a  [DMA_CHN_NUM];
    logic [ATX_LEN_W-1:0]     arlen_a   [DMA_CHN_NUM];
    logic [1:0]               arburst_a [DMA_CHN_NUM];
    logic [MST_ID_W-1:0]      awid_a    [DMA_CHN_NUM];
    logic [DST_ADDR_W-1:0]    awaddr_a  [DMA_CHN_NUM];
    logic [ATX_LEN_W-1:0]     awlen_a   [DMA_CHN_NUM];
    logic [1:0]               awburst_a [DMA_CHN_NUM];
    logic [DMA_CHN_ARB_W-1:0] rate_eff  [DMA_CHN_NUM];

    logic [DMA_CHN_NUM-1:0]   elig;
    logic [DMA_CHN_NUM_W-1:0] ptr;
    logic [DMA_CHN_ARB_W-1:0] cred;
    logic [DMA_CHN_NUM_W-1:0] sel;
    logic [DMA_CHN_NUM_W-1:0] scan_idx;
    logic                     sel_vld;
    logic                     load_ok;
    logic                     accept;

    // Split the packed per-channel buses into arrays.
    // A rate of 0 is treated as a weight of 1.
    for (genvar i = 0; i < DMA_CHN_NUM; i++) begin : g_unpack
        assign arid_a[i]    = bwd_arid[i*MST_ID_W +: MST_ID_W];
        assign araddr_a[i]  = bwd_araddr[i*SRC_ADDR_W +: SRC_ADDR_W];
        assign arlen_a[i]   = bwd_arlen[i*ATX_LEN_W +: ATX_LEN_W];
        assign arburst_a[i] = bwd_arburst[i*2 +: 2];
        assign awid_a[i]    = bwd_awid[i*MST_ID_W +: MST_ID_W];
        assign awaddr_a[i]  = bwd_awaddr[i*DST_ADDR_W +: DST_ADDR_W];
        assign awlen_a[i]   = bwd_awlen[i*ATX_LEN_W +: ATX_LEN_W];
        assign awburst_a[i] = bwd_awburst[i*2 +: 2];
        assign rate_eff[i]  = (chn_arb_rate[i*DMA_CHN_ARB_W +: DMA_CHN_ARB_W] == '0)
                            ? DMA_CHN_ARB_W'(1)
                            : chn_arb_rate[i*DMA_CHN_ARB_W +: DMA_CHN_ARB_W];
    end

`ifdef ADMA_ATX_ARB_OSTD_LIMIT_EN
    localparam int OSTD_W = $clog2(CHN_OSTD_MAX + 1);
    localparam logic [OSTD_W-1:0] OSTD_MAX_V = OSTD_W'(CHN_OSTD_MAX);

    // Count in-flight transactions per channel. A done pulse at zero is dropped.
    for (genvar i = 0; i < DMA_CHN_NUM; i++) begin : g_ostd
        logic [OSTD_W-1:0] cnt;
        logic              inc;
        logic              dec;

        assign inc     = bwd_atx_rdy[i] && bwd_atx_vld[i];
        assign dec     = atx_done[i] && (cnt != '0);
        assign elig[i] = bwd_atx_vld[i] && (cnt < OSTD_MAX_V);

        // Increment on accept and decrement on done; when both happen the count is unchanged.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (inc && !dec) begin
                cnt <= cnt + OSTD_W'(1);
            end else if (dec && !inc) begin
                cnt <= cnt - OSTD_W'(1);
            end
        end
    end
`else
    localparam int unused_ostd_max = CHN_OSTD_MAX;
    logic unused_atx_done;
    assign unused_atx_done = ^atx_done;
    assign elig            = bwd_atx_vld;
`endif

    assign load_ok = !fwd_atx_vld || fwd_atx_rdy;

    // Choose a channel. The turn owner keeps the grant while it has credit left.
    // Otherwise scan from ptr+1 with wrap-around, ending at ptr itself.
    always_comb begin
        sel      = ptr;
        sel_vld  = 1'b0;
        scan_idx = ptr;
        if (elig[ptr] && (cred < rate_eff[ptr])) begin
            sel_vld = 1'b1;
        end else begin
            for (int k = 1; k <= DMA_CHN_NUM; k++) begin
                scan_idx = DMA_CHN_NUM_W'((int'(ptr) + k) % DMA_CHN_NUM);
                if (!sel_vld && elig[scan_idx]) begin
                    sel     = scan_idx;
                    sel_vld = 1'b1;
                end
            end
        end
    end

    // Raise ready only for the selected channel, and only while the slice can load.
    // Ready is held low during reset.
    for (genvar i = 0; i < DMA_CHN_NUM; i++) begin : g_rdy
        assign bwd_atx_rdy[i] = !rst && load_ok && sel_vld && (sel == DMA_CHN_NUM_W'(i));
    end

    assign accept = |(bwd_atx_rdy & bwd_atx_vld);

    // Track the turn owner and the number of grants it has used in this turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= '0;
            cred <= '0;
        end else if (accept) begin
            if ((sel == ptr) && (cred < rate_eff[sel])) begin
                cred <= cred + 1'b1;
            end else begin
                ptr  <= sel;
                cred <= DMA_CHN_ARB_W'(1);
            end
        end
    end

    // Forward register slice. Data is held while the downstream side stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_atx_vld    <= 1'b0;
            fwd_atx_chn_id <= '0;
            fwd_arid       <= '0;
            fwd_araddr     <= '0;
            fwd_arlen      <= '0;
            fwd_arburst    <= '0;
            fwd_awid       <= '0;
            fwd_awaddr     <= '0;
            fwd_awlen      <= '0;
            fwd_awburst    <= '0;
        end else if (accept) begin
            fwd_atx_vld    <= 1'b1;
            fwd_atx_chn_id <= sel;
            fwd_arid       <= arid_a[sel];
            fwd_araddr     <= araddr_a[sel];
            fwd_arlen      <= arlen_a[sel];
            fwd_arburst    <= arburst_a[sel];
            fwd_awid       <= awid_a[sel];
            fwd_awaddr     <= awaddr_a[sel];
            fwd_awlen      <= awlen_a[sel];
            fwd_awburst    <= awburst_a[sel];
        end else if (fwd_atx_rdy) begin
            fwd_atx_vld    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adma_atx_wrr_arb.sv
// Directed bench for adma_atx_wrr_arb. Each channel drives fixed, distinct request fields.
// The bench checks which channel is granted and what data is forwarded.
module tb_adma_atx_wrr_arb;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N*5-1:0]  bwd_arid, bwd_awid;
    logic [N*32-1:0] bwd_araddr, bwd_awaddr;
    logic [N*8-1:0]  bwd_arlen, bwd_awlen;
    logic [N*2-1:0]  bwd_arburst, bwd_awburst;
    logic [N-1:0]    bwd_atx_vld, bwd_atx_rdy, atx_done;
    logic [N*3-1:0]  chn_arb_rate;
    logic [1:0]      fwd_atx_chn_id;
    logic [4:0]      fwd_arid, fwd_awid;
    logic [31:0]     fwd_araddr, fwd_awaddr;
    logic [7:0]      fwd_arlen, fwd_awlen;
    logic [1:0]      fwd_arburst, fwd_awburst;
    logic            fwd_atx_vld, fwd_atx_rdy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    adma_atx_wrr_arb #(
        .DMA_CHN_NUM(4), .DMA_CHN_ARB_W(3), .SRC_ADDR_W(32), .DST_ADDR_W(32),
        .MST_ID_W(5), .ATX_LEN_W(8), .CHN_OSTD_MAX(2)
    ) dut (
        .clk(clk), .rst(rst),
        .bwd_arid(bwd_arid), .bwd_araddr(bwd_araddr), .bwd_arlen(bwd_arlen),
        .bwd_arburst(bwd_arburst), .bwd_awid(bwd_awid), .bwd_awaddr(bwd_awaddr),
        .bwd_awlen(bwd_awlen), .bwd_awburst(bwd_awburst),
        .bwd_atx_vld(bwd_atx_vld), .bwd_atx_rdy(bwd_atx_rdy),
        .chn_arb_rate(chn_arb_rate), .atx_done(atx_done),
        .fwd_atx_chn_id(fwd_atx_chn_id), .fwd_arid(fwd_arid), .fwd_araddr(fwd_araddr),
        .fwd_arlen(fwd_arlen), .fwd_arburst(fwd_arburst), .fwd_awid(fwd_awid),
        .fwd_awaddr(fwd_awaddr), .fwd_awlen(fwd_awlen), .fwd_awburst(fwd_awburst),
        .fwd_atx_vld(fwd_atx_vld), .fwd_atx_rdy(fwd_atx_rdy)
    );

    function automatic logic [31:0] exp_araddr(input int c);
        return 32'h1000_0000 + 32'(c) * 32'h0001_0100;
    endfunction

    function automatic logic [31:0] exp_awaddr(input int c);
        return 32'h8000_0000 + 32'(c) * 32'h0000_0040;
    endfunction

    task automatic init_fields();
        for (int c = 0; c < N; c++) begin
            bwd_araddr[c*32 +: 32] = exp_araddr(c);
            bwd_awaddr[c*32 +: 32] = exp_awaddr(c);
            bwd_arid[c*5 +: 5]     = 5'(c + 1);
            bwd_awid[c*5 +: 5]     = 5'(c + 17);
            bwd_arlen[c*8 +: 8]    = 8'(c * 3 + 1);
            bwd_awlen[c*8 +: 8]    = 8'(c * 3 + 2);
            bwd_arburst[c*2 +: 2]  = 2'b01;
            bwd_awburst[c*2 +: 2]  = 2'b10;
        end
        bwd_atx_vld  = '0;
        atx_done     = '0;
        fwd_atx_rdy  = 1'b1;
        chn_arb_rate = {3'd1, 3'd1, 3'd1, 3'd1};
    endtask

    // Pulses reset for two cycles and returns at a falling edge with rst released.
    task automatic apply_reset();
        bwd_atx_vld = '0;
        atx_done    = '0;
        fwd_atx_rdy = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bwd_atx_vld = 4'hF;
        #2 rst = 1'b1;
        @(negedge clk); #1;
        vec_cnt++;
        if (fwd_atx_vld !== 1'b0 || fwd_atx_chn_id !== 2'd0 || fwd_araddr !== 32'd0 ||
            fwd_awid !== 5'd0 || fwd_awlen !== 8'd0 || fwd_awaddr !== 32'd0) begin
            err_cnt++;
            $display("FAIL reset_fwd vld=%b id=%0d araddr=%h awid=%0d awlen=%0d awaddr=%h exp all 0",
                     fwd_atx_vld, fwd_atx_chn_id, fwd_araddr, fwd_awid, fwd_awlen, fwd_awaddr);
        end
        vec_cnt++;
        if (bwd_atx_rdy !== 4'b0000) begin
            err_cnt++; $display("FAIL reset_rdy got=%b exp=0000", bwd_atx_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (bwd_atx_rdy !== 4'b0001) begin
            err_cnt++; $display("FAIL first_grant_rdy got=%b exp=0001", bwd_atx_rdy);
        end
        @(negedge clk);
        fwd_atx_rdy = 1'b0;
        #1;
        vec_cnt++;
        if (fwd_atx_vld !== 1'b1 || fwd_atx_chn_id !== 2'd0 || fwd_araddr !== exp_araddr(0) ||
            fwd_arid !== 5'd1 || fwd_awaddr !== exp_awaddr(0) || fwd_awburst !== 2'b10) begin
            err_cnt++;
            $display("FAIL first_grant_fwd vld=%b id=%0d araddr=%h arid=%0d awaddr=%h burst=%b exp 1/0/%h/1/%h/10",
                     fwd_atx_vld, fwd_atx_chn_id, fwd_araddr, fwd_arid, fwd_awaddr, fwd_awburst,
                     exp_araddr(0), exp_awaddr(0));
        end
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if (fwd_atx_vld !== 1'b0 || fwd_araddr !== 32'd0) begin
            err_cnt++;
            $display("FAIL async_reset_drop vld=%b araddr=%h exp 0/0", fwd_atx_vld, fwd_araddr);
        end
        @(negedge clk);
        rst = 1'b0;
        fwd_atx_rdy = 1'b1;
    endtask

    task automatic test_wrr();
        int pat [7];
        int g;
        int pg;
        pat = '{0, 1, 1, 2, 2, 2, 3};
        apply_reset();
        chn_arb_rate = {3'd1, 3'd3, 3'd2, 3'd1};
        bwd_atx_vld  = 4'hF;
        atx_done     = 4'hF;
        fwd_atx_rdy  = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #1;
            g = pat[c % 7];
            vec_cnt++;
            if (bwd_atx_rdy !== 4'(1 << g)) begin
                err_cnt++; $display("FAIL wrr_rdy c=%0d got=%b exp_chn=%0d", c, bwd_atx_rdy, g);
            end
            if (c > 0) begin
                pg = pat[(c - 1) % 7];
                vec_cnt++;
                if (fwd_atx_vld !== 1'b1 || fwd_atx_chn_id !== 2'(pg) ||
                    fwd_araddr !== exp_araddr(pg) || fwd_awlen !== 8'(pg * 3 + 2)) begin
                    err_cnt++;
                    $display("FAIL wrr_fwd c=%0d vld=%b id=%0d araddr=%h awlen=%0d exp_chn=%0d",
                             c, fwd_atx_vld, fwd_atx_chn_id, fwd_araddr, fwd_awlen, pg);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int seq [4];
        seq = '{1, 2, 3, 0};
        apply_reset();
        chn_arb_rate = {3'd1, 3'd1, 3'd1, 3'd1};
        bwd_atx_vld  = 4'hF;
        atx_done     = 4'hF;
        fwd_atx_rdy  = 1'b1;
        #1;
        vec_cnt++;
        if (bwd_atx_rdy !== 4'b0001) begin
            err_cnt++; $display("FAIL bp_first got=%b exp=0001", bwd_atx_rdy);
        end
        @(negedge clk);
        fwd_atx_rdy = 1'b0;
        bwd_araddr[0 +: 32] = 32'hDEAD_BEEF;
        for (int s = 0; s < 5; s++) begin
            #1;
            vec_cnt++;
            if (bwd_atx_rdy !== 4'b0000 || fwd_atx_vld !== 1'b1 || fwd_atx_chn_id !== 2'd0 ||
                fwd_araddr !== exp_araddr(0)) begin
                err_cnt++;
                $display("FAIL bp_stall s=%0d rdy=%b vld=%b id=%0d araddr=%h exp 0000/1/0/%h",
                         s, bwd_atx_rdy, fwd_atx_vld, fwd_atx_chn_id, fwd_araddr, exp_araddr(0));
            end
            @(negedge clk);
        end
        fwd_atx_rdy = 1'b1;
        bwd_araddr[0 +: 32] = exp_araddr(0);
        for (int k = 0; k < 4; k++) begin
            #1;
            vec_cnt++;
            if (bwd_atx_rdy !== 4'(1 << seq[k]) || fwd_atx_vld !== 1'b1 ||
                fwd_atx_chn_id !== 2'((k == 0) ? 0 : seq[k - 1])) begin
                err_cnt++;
                $display("FAIL bp_release k=%0d rdy=%b vld=%b id=%0d exp_grant=%0d",
                         k, bwd_atx_rdy, fwd_atx_vld, fwd_atx_chn_id, seq[k]);
            end
            @(negedge clk);
        end
        #1;
        vec_cnt++;
        if (fwd_atx_vld !== 1'b1 || fwd_atx_chn_id !== 2'd0 || fwd_araddr !== exp_araddr(0)) begin
            err_cnt++;
            $display("FAIL bp_tail vld=%b id=%0d araddr=%h exp 1/0/%h",
                     fwd_atx_vld, fwd_atx_chn_id, fwd_araddr, exp_araddr(0));
        end
        @(negedge clk);
    endtask

    // Only channel 2 requests. The same done pattern is used in both builds.
    task automatic test_ostd_limit();
        logic [3:0] done_t [9];
        logic [3:0] rdy_t  [9];
        logic       exp_vld;
        done_t = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
`ifdef ADMA_ATX_ARB_OSTD_LIMIT_EN
        rdy_t  = '{4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0};
`else
        rdy_t  = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
`endif
        apply_reset();
        chn_arb_rate = {3'd1, 3'd1, 3'd1, 3'd1};
        bwd_atx_vld  = 4'b0100;
        fwd_atx_rdy  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            atx_done = done_t[c];
            #1;
            exp_vld = (c > 0) && (rdy_t[c - 1] != 4'h0);
            vec_cnt++;
            if (bwd_atx_rdy !== rdy_t[c] || fwd_atx_vld !== exp_vld ||
                (exp_vld && fwd_atx_chn_id !== 2'd2)) begin
                err_cnt++;
                $display("FAIL ostd c=%0d rdy=%b exp=%b vld=%b exp_vld=%b id=%0d",
                         c, bwd_atx_rdy, rdy_t[c], fwd_atx_vld, exp_vld, fwd_atx_chn_id);
            end
            @(negedge clk);
        end
        atx_done = '0;
    endtask

    task automatic test_zero_rate();
        apply_reset();
        chn_arb_rate = {3'd1, 3'd1, 3'd0, 3'd1};
        bwd_atx_vld  = 4'b0011;
        atx_done     = 4'hF;
        fwd_atx_rdy  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            vec_cnt++;
            if (bwd_atx_rdy !== ((c % 2 == 0) ? 4'b0001 : 4'b0010)) begin
                err_cnt++;
                $display("FAIL zero_rate c=%0d got=%b exp_chn=%0d", c, bwd_atx_rdy, c % 2);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        init_fields();
        test_reset();
        test_wrr();
        test_backpressure();
        test_ostd_limit();
        test_zero_rate();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
